// File: rtl/fp_div_if.sv
// Handshake bundle for the fp_32 divider: operand request channel and result channel.
interface fp_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_div.sv
// Iterative fp_32 divider: one restoring-division quotient bit per cycle, truncated result,
// denormals flushed to zero. One division in flight; valid/ready on both sides.
module fp_div #(
  parameter logic [31:0] QNAN  = 32'h7FC0_0000,
  parameter int unsigned ITERS = 25
) (
  input logic       clk,
  input logic       rst,
  fp_div_if.slave   bus
);

  localparam int unsigned CntW = $clog2(ITERS);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e            state_q, state_d;
  logic              sgn_q, sgn_d;
  logic [7:0]        ea_q, ea_d, eb_q, eb_d;
  logic [25:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [24:0]       quo_q, quo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;

  // Operand classification on the live request bus.
  logic        sgn_in;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        is_special;
  logic [31:0] special_res;

  always_comb begin
    sgn_in = bus.a[31] ^ bus.b[31];
    a_zero = (bus.a[30:23] == 8'h00);
    b_zero = (bus.b[30:23] == 8'h00);
    a_inf  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'h0);
    b_inf  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] == 23'h0);
    a_nan  = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'h0);
    b_nan  = (bus.b[30:23] == 8'hFF) && (bus.b[22:0] != 23'h0);
    is_special  = 1'b1;
    special_res = QNAN;
    if (a_nan || b_nan) begin
      special_res = QNAN;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      special_res = QNAN;
    end else if (a_inf || b_zero) begin
      special_res = {sgn_in, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      special_res = {sgn_in, 31'h0};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step.
  logic        q_bit;
  logic [25:0] rem_sub;

  always_comb begin
    q_bit   = (rem_q >= {2'b00, div_q});
    rem_sub = q_bit ? (rem_q - {2'b00, div_q}) : rem_q;
  end

  // Normalisation and exponent range check on the finished quotient.
  logic signed [9:0] exp_raw, exp_fin;
  logic [22:0]       man;
  logic [31:0]       norm_res;

  always_comb begin
    exp_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    exp_fin = quo_q[24] ? exp_raw : exp_raw - 10'sd1;
    man     = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    if (exp_fin >= 10'sd255) begin
      norm_res = {sgn_q, 8'hFF, 23'h0};
    end else if (exp_fin <= 10'sd0) begin
      norm_res = {sgn_q, 31'h0};
    end else begin
      norm_res = {sgn_q, exp_fin[7:0], man};
    end
  end

  always_comb begin
    state_d  = state_q;
    sgn_d    = sgn_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sgn_d = sgn_in;
          ea_d  = bus.a[30:23];
          eb_d  = bus.b[30:23];
          rem_d = {3'b001, bus.a[22:0]};
          div_d = {1'b1, bus.b[22:0]};
          quo_d = '0;
          cnt_d = '0;
          if (is_special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d  = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[23:0], q_bit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITERS - 1)) begin
          cnt_d   = '0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        result_d = norm_res;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sgn_q    <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sgn_q    <= sgn_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vector table, backpressure and reset sequences,
// then randomized operands against an arithmetic reference model.
module tb_fp_div;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  // Latency = posedges after the accept edge before out_valid is first visible.
  localparam int LAT_SPECIAL = 0;
  localparam int LAT_NORMAL  = 26;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fp_div_if bus ();

  fp_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact truncated quotient via integer division, then IEEE packing rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    logic  sgn;
    int    ea, eb, e;
    longint ma, mb, q, m;
    sgn = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    ma  = longint'(a[22:0]);
    mb  = longint'(b[22:0]);
    special = 1'b1;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return QNAN;
    if ((ea == 255 && eb == 255) || (ea == 0 && eb == 0)) return QNAN;
    if (ea == 255 || eb == 0) return {sgn, 8'hFF, 23'h0};
    if (ea == 0 || eb == 255) return {sgn, 31'h0};
    special = 1'b0;
    q = ((ma + 64'd8388608) * 64'd16777216) / (mb + 64'd8388608);
    e = ea - eb + 127;
    if (q >= 64'd16777216) begin
      m = q / 2;
    end else begin
      m = q;
      e = e - 1;
    end
    m = m % 64'd8388608;
    if (e >= 255) return {sgn, 8'hFF, 23'h0};
    if (e <= 0) return {sgn, 31'h0};
    return {sgn, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = int'($urandom_range(0, 15));
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'($urandom_range(1, 254));
    else             e = 8'($urandom_range(100, 154));
    m = 23'($urandom);
    if (e == 8'hFF && $urandom_range(0, 1) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int n;
    bit busy_ok;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    n            = 0;
    busy_ok      = 1'b1;
    while (!bus.out_valid && n < 60) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    check({name, " result"}, bus.result, exp_res);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'h3F80_0000;
      bus.b        = 32'h4000_0000;
      @(negedge clk);
      check({name, " hold valid"}, 32'(bus.out_valid), 32'd1);
      check({name, " hold result"}, bus.result, exp_res);
      check({name, " hold ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " drained"}, 32'(bus.out_valid), 32'd0);
    check({name, " idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    bit          sp;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORMAL};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORMAL};
    vecs[2]  = '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, LAT_NORMAL};
    vecs[3]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, LAT_SPECIAL};
    vecs[4]  = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, LAT_SPECIAL};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, QNAN,          LAT_SPECIAL};
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, QNAN,          LAT_SPECIAL};
    vecs[7]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, LAT_SPECIAL};
    vecs[8]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, LAT_NORMAL};
    vecs[9]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, LAT_NORMAL};
    vecs[10] = '{32'h7FC1_2345, 32'h0000_0000, QNAN,          LAT_SPECIAL};
    vecs[11] = '{32'h0012_3456, 32'h4000_0000, 32'h0000_0000, LAT_SPECIAL};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", bus.result, 32'h0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0);
    end

    // Backpressure, then a different operand pair must be the one accepted next.
    run_op("bp", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORMAL, 10);
    run_op("after bp", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORMAL, 0);

    // Reset during iteration 12 abandons the division.
    bus.a        = 32'h40C0_0000;
    bus.b        = 32'h4000_0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset result", bus.result, 32'h0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    repeat (30) @(negedge clk);
    check("midreset no output", 32'(bus.out_valid), 32'd0);
    run_op("post reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORMAL, 0);

    for (int i = 0; i < 150; i++) begin
      ra   = rand_fp();
      rb   = rand_fp();
      rexp = ref_div(ra, rb, sp);
      run_op($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, rexp,
             sp ? LAT_SPECIAL : LAT_NORMAL, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
